// File: rtl/pc_fetch_pkg.sv
// Shared encodings and payload types for the PC / instruction-fetch stage.
package pc_fetch_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_BR  = 2'b01,
    PC_J   = 2'b10,
    PC_JR  = 2'b11
  } pc_src_e;

  typedef enum logic [1:0] {
    ST_REQ  = 2'b00,
    ST_DROP = 2'b01,
    ST_FULL = 2'b10
  } fetch_state_e;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_pkt_t;

endpackage

// File: rtl/pc_fetch_next_pc_calc.sv
// Redirect target for the instruction held in decode: branch, jump or register jump.
module next_pc_calc
  import pc_fetch_pkg::*;
(
  input  logic [XLEN-1:0] inst_pc_i,
  input  logic [25:0]     inst_i,
  input  logic [XLEN-1:0] rs_val_i,
  input  logic [1:0]      pc_src_i,
  output logic [XLEN-1:0] target_c_o
);

  logic [XLEN-1:0] p4;
  logic [XLEN-1:0] br_off;

  assign p4     = inst_pc_i + XLEN'(4);
  assign br_off = {{14{inst_i[15]}}, inst_i[15:0], 2'b00};

  always_comb begin
    target_c_o = p4;
    case (pc_src_e'(pc_src_i))
      PC_BR:   target_c_o = p4 + br_off;
      PC_J:    target_c_o = {p4[31:28], inst_i[25:0], 2'b00};
      PC_JR:   target_c_o = rs_val_i;
      default: target_c_o = p4;
    endcase
  end

endmodule

// File: rtl/pc_fetch.sv
// PC register, req/ack fetch port with a one-entry skid buffer, decode-facing
// instruction register and a saturating count of squashed fetches.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0]  RESET_PC     = 32'h0000_0000,
  parameter int unsigned  SQUASH_CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  input  logic [1:0]              pc_src,
  input  logic [XLEN-1:0]         rs_val,
  output logic                    imem_req,
  output logic [XLEN-1:0]         imem_addr,
  input  logic                    imem_ack,
  input  logic [XLEN-1:0]         imem_rdata,
  output logic [XLEN-1:0]         inst_out,
  output logic [XLEN-1:0]         inst_pc,
  output logic                    inst_valid,
  output logic [SQUASH_CNT_W-1:0] squash_cnt
);

  fetch_state_e            state_q, state_d;
  logic [XLEN-1:0]         pc_q, pc_d;
  logic [XLEN-1:0]         addr_q, addr_d;
  fetch_pkt_t              inst_q, inst_d;
  fetch_pkt_t              skid_q, skid_d;
  logic                    valid_q, valid_d;
  logic                    req_q, req_d;
  logic [SQUASH_CNT_W-1:0] squash_q, squash_d;
  logic                    squash_inc;

  logic                    consume;
  logic                    redirect;
  logic                    slot_free;
  logic [XLEN-1:0]         target;

  assign consume   = valid_q & ~stall;
  assign redirect  = consume & (pc_src_e'(pc_src) != PC_SEQ);
  assign slot_free = ~valid_q | consume;

  next_pc_calc u_next_pc_calc (
    .inst_pc_i  (inst_q.pc),
    .inst_i     (inst_q.inst[25:0]),
    .rs_val_i   (rs_val),
    .pc_src_i   (pc_src),
    .target_c_o (target)
  );

  // Next-state, fetch address and decode-register update.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    inst_d     = inst_q;
    skid_d     = skid_q;
    valid_d    = valid_q;
    squash_inc = 1'b0;

    case (state_q)
      ST_REQ: begin
        if (redirect) begin
          pc_d    = target;
          valid_d = 1'b0;
          if (imem_ack) begin
            squash_inc = 1'b1;
            addr_d     = target;
          end else begin
            state_d = ST_DROP;
          end
        end else if (imem_ack) begin
          if (slot_free) begin
            inst_d  = '{pc: addr_q, inst: imem_rdata};
            valid_d = 1'b1;
          end else begin
            skid_d  = '{pc: addr_q, inst: imem_rdata};
            state_d = ST_FULL;
          end
          addr_d = addr_q + XLEN'(4);
          pc_d   = addr_q + XLEN'(4);
        end else if (consume) begin
          valid_d = 1'b0;
        end
      end
      // Wrong-path request still outstanding; swallow its data before refetching.
      ST_DROP: begin
        if (imem_ack) begin
          squash_inc = 1'b1;
          addr_d     = pc_q;
          state_d    = ST_REQ;
        end
      end
      ST_FULL: begin
        if (redirect) begin
          squash_inc = 1'b1;
          addr_d     = target;
          pc_d       = target;
          valid_d    = 1'b0;
          state_d    = ST_REQ;
        end else if (consume) begin
          inst_d  = skid_q;
          valid_d = 1'b1;
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase

    squash_d = (squash_inc && (squash_q != '1)) ? squash_q + SQUASH_CNT_W'(1) : squash_q;
    req_d    = (state_d != ST_FULL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_REQ;
      pc_q     <= RESET_PC;
      addr_q   <= RESET_PC;
      inst_q   <= '0;
      skid_q   <= '0;
      valid_q  <= 1'b0;
      req_q    <= 1'b1;
      squash_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      inst_q   <= inst_d;
      skid_q   <= skid_d;
      valid_q  <= valid_d;
      req_q    <= req_d;
      squash_q <= squash_d;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign inst_out   = inst_q.inst;
  assign inst_pc    = inst_q.pc;
  assign inst_valid = valid_q;
  assign squash_cnt = squash_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: directed fetch/redirect/skid/reset scenarios, then random
// stall/ack/redirect traffic checked against a program-order reference model.
module tb_pc_fetch;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [1:0]  pc_src;
  logic [31:0] rs_val;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic [15:0] squash_cnt;

  int checks;
  int failures;

  pc_fetch #(
    .RESET_PC     (32'h0000_0000),
    .SQUASH_CNT_W (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .pc_src     (pc_src),
    .rs_val     (rs_val),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst_out   (inst_out),
    .inst_pc    (inst_pc),
    .inst_valid (inst_valid),
    .squash_cnt (squash_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Instruction memory contents: a hash of the address plus two planted words.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h1000_FFFE;
    if (a == 32'h9000_0010) return 32'h0800_0040;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Architectural successor of the instruction at pc.
  function automatic logic [31:0] ref_target(input logic [31:0] pc, input logic [31:0] inst,
                                              input logic [31:0] rs, input logic [1:0] src);
    logic signed [31:0] off;
    off = $signed(inst[15:0]);
    case (src)
      2'd1:    return pc + 32'd4 + 32'(off * 4);
      2'd2:    return ((pc + 32'd4) & 32'hF000_0000) | ((inst & 32'h03FF_FFFF) << 2);
      2'd3:    return rs;
      default: return pc + 32'd4;
    endcase
  endfunction

  // Drive one cycle of inputs at a falling edge; memory answers only while req is high.
  task automatic step(input logic s, input logic [1:0] src, input logic [31:0] rs, input logic a);
    stall      = s;
    pc_src     = src;
    rs_val     = rs;
    imem_ack   = a & imem_req;
    imem_rdata = mem_word(imem_addr);
    @(negedge clk);
  endtask

  task automatic chk_zero_state(input string tag);
    chk({tag, "_valid"}, 32'(inst_valid), 32'd0);
    chk({tag, "_out"},   inst_out,        32'd0);
    chk({tag, "_pc"},    inst_pc,         32'd0);
    chk({tag, "_sq"},    32'(squash_cnt), 32'd0);
    chk({tag, "_req"},   32'(imem_req),   32'd1);
    chk({tag, "_addr"},  imem_addr,       32'd0);
  endtask

  logic [31:0] exp_pc;
  logic [31:0] prev_addr;
  logic [31:0] rs;
  logic [1:0]  src;
  logic        s;
  logic        a;
  logic        prev_hold;
  int          redirects;
  int          consumed;

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; stall = 1'b0; pc_src = 2'd0; rs_val = '0; imem_ack = 1'b0; imem_rdata = '0;
    @(negedge clk); @(negedge clk);
    chk_zero_state("reset");
    reset = 1'b0;

    // Back-to-back sequential fetch.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 2'd0, 32'd0, 1'b1);
      chk("seq_pc", inst_pc, 32'(i * 4));
      chk("seq_valid", 32'(inst_valid), 32'd1);
      chk("seq_req", 32'(imem_req), 32'd1);
    end

    // jr to 0x100 with the in-flight fetch still outstanding.
    step(1'b0, 2'd3, 32'h0000_0100, 1'b0);
    chk("drop_valid", 32'(inst_valid), 32'd0);
    chk("drop_addr", imem_addr, 32'h0000_0010);
    chk("drop_req", 32'(imem_req), 32'd1);
    step(1'b0, 2'd0, 32'd0, 1'b1);
    chk("drop_sq", 32'(squash_cnt), 32'd1);
    chk("drop_tgt", imem_addr, 32'h0000_0100);
    step(1'b0, 2'd0, 32'd0, 1'b1);
    chk("br_src_pc", inst_pc, 32'h0000_0100);
    chk("br_src_inst", inst_out, 32'h1000_FFFE);
    // Backward branch with the wrong-path ack in the same cycle.
    step(1'b0, 2'd1, 32'd0, 1'b1);
    chk("br_addr", imem_addr, 32'h0000_00FC);
    chk("br_sq", 32'(squash_cnt), 32'd2);
    chk("br_valid", 32'(inst_valid), 32'd0);
    step(1'b0, 2'd0, 32'd0, 1'b1);
    chk("br_pc", inst_pc, 32'h0000_00FC);

    // Jump keeps the upper nibble of pc+4; then a register jump.
    step(1'b0, 2'd3, 32'h9000_0010, 1'b1);
    chk("jr1_sq", 32'(squash_cnt), 32'd3);
    step(1'b0, 2'd0, 32'd0, 1'b1);
    chk("j_src_pc", inst_pc, 32'h9000_0010);
    step(1'b0, 2'd2, 32'd0, 1'b0);
    step(1'b0, 2'd0, 32'd0, 1'b1);
    chk("j_addr", imem_addr, 32'h9000_0100);
    chk("j_sq", 32'(squash_cnt), 32'd4);
    step(1'b0, 2'd0, 32'd0, 1'b1);
    step(1'b0, 2'd3, 32'h0000_1234, 1'b0);
    step(1'b0, 2'd0, 32'd0, 1'b1);
    chk("jr_addr", imem_addr, 32'h0000_1234);
    chk("jr_sq", 32'(squash_cnt), 32'd5);

    // Stall while an ack lands: skid fills, request drops, then drains in order.
    step(1'b0, 2'd0, 32'd0, 1'b1);
    chk("full_pre_pc", inst_pc, 32'h0000_1234);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'd0, 32'd0, 1'b1);
      chk("full_req", 32'(imem_req), 32'd0);
      chk("full_hold_pc", inst_pc, 32'h0000_1234);
      chk("full_hold_inst", inst_out, mem_word(32'h0000_1234));
    end
    step(1'b0, 2'd0, 32'd0, 1'b0);
    chk("skid_pc", inst_pc, 32'h0000_1238);
    chk("skid_inst", inst_out, mem_word(32'h0000_1238));
    chk("skid_req", 32'(imem_req), 32'd1);
    chk("skid_addr", imem_addr, 32'h0000_123C);
    step(1'b0, 2'd0, 32'd0, 1'b1);
    chk("post_skid_pc", inst_pc, 32'h0000_123C);

    // Redirect while FULL discards the skid entry.
    step(1'b1, 2'd0, 32'd0, 1'b1);
    chk("full2_req", 32'(imem_req), 32'd0);
    step(1'b0, 2'd3, 32'h0000_2000, 1'b0);
    chk("fullred_sq", 32'(squash_cnt), 32'd6);
    chk("fullred_addr", imem_addr, 32'h0000_2000);
    chk("fullred_valid", 32'(inst_valid), 32'd0);
    chk("fullred_req", 32'(imem_req), 32'd1);
    step(1'b0, 2'd0, 32'd0, 1'b1);
    chk("fullred_pc", inst_pc, 32'h0000_2000);

    // Reset in the middle of a slow DROP; the late ack answers the reset fetch.
    step(1'b0, 2'd3, 32'h0000_3000, 1'b0);
    chk("rdrop_addr", imem_addr, 32'h0000_2004);
    step(1'b0, 2'd0, 32'd0, 1'b0);
    step(1'b0, 2'd0, 32'd0, 1'b0);
    reset = 1'b1;
    #1;
    chk_zero_state("midrst");
    @(negedge clk);
    reset = 1'b0;
    step(1'b0, 2'd0, 32'd0, 1'b1);
    chk("midrst_pc", inst_pc, 32'd0);
    chk("midrst_inst", inst_out, mem_word(32'd0));
    chk("midrst_valid", 32'(inst_valid), 32'd1);

    // Random traffic against the program-order model.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_pc = 32'd0; redirects = 0; consumed = 0; prev_hold = 1'b0; prev_addr = '0;
    for (int cyc = 0; cyc < 3020; cyc++) begin
      if (prev_hold) begin
        chk("addr_hold", imem_addr, prev_addr);
        chk("req_hold", 32'(imem_req), 32'd1);
      end
      if (inst_valid) begin
        chk("rnd_pc", inst_pc, exp_pc);
        chk("rnd_inst", inst_out, mem_word(exp_pc));
      end
      if (cyc < 3000) begin
        s   = ($urandom_range(0, 3) == 0);
        src = ($urandom_range(0, 9) < 6) ? 2'd0 : 2'($urandom_range(1, 3));
        rs  = $urandom;
        a   = 1'($urandom_range(0, 1));
      end else begin
        s = 1'b0; src = 2'd0; rs = '0; a = 1'b1;
      end
      if (inst_valid && !s) begin
        consumed++;
        if (src != 2'd0) redirects++;
        exp_pc = ref_target(exp_pc, mem_word(exp_pc), rs, src);
      end
      prev_hold = imem_req & ~a;
      prev_addr = imem_addr;
      step(s, src, rs, a);
    end
    chk("progress", 32'(consumed >= 300), 32'd1);
    chk("rnd_squash", 32'(squash_cnt), 32'(redirects));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
